normalize_shift: RTL and testbench

- Iterative left-normalizer for the ALU datapath.
- Shifts operand A left, one bit per clock, until its MSB is 1. Reports the normalized value and the shift count.
- The shift count is encoded in the ALU logic-shift control format: bit [BUS_WIDTH_BITS] = direction (1 = left, 0 = right), low bits = amount.
- Feeding Y and SHAMT back into the ALU logic shift unit therefore performs the reverse (right) shift and reconstructs A.
- Used ahead of priority/leading-zero instructions and software normalization helpers.

---
 rtl/normalize_shift_if.sv | 23 ++
 rtl/normalize_shift.sv | 88 ++++++++
 tb/tb_normalize_shift.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/normalize_shift_if.sv
// Handshake and result bundle between an ALU sequencer and the iterative normalizer.
interface normalize_shift_if #(
    parameter int BUS_WIDTH      = 8,
    parameter int BUS_WIDTH_BITS = 3
) ();
    logic                      start;
    logic [BUS_WIDTH-1:0]      A;
    logic                      busy;
    logic                      done;
    logic [BUS_WIDTH-1:0]      Y;
    logic [BUS_WIDTH_BITS:0]   SHAMT;
    logic                      ZERO;

    modport master (
        output start, A,
        input  busy, done, Y, SHAMT, ZERO
    );

    modport slave (
        input  start, A,
        output busy, done, Y, SHAMT, ZERO
    );
endinterface

// File: rtl/normalize_shift.sv
// Iterative left-normalizer: shifts A left one bit per clock until its MSB is set,
// reporting the result and a right-shift control word that restores A.
module normalize_shift #(
    parameter int BUS_WIDTH      = 8,
    parameter int BUS_WIDTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    normalize_shift_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    state_q, state_d;
    logic [BUS_WIDTH-1:0]      work_q, work_d;
    logic [BUS_WIDTH_BITS-1:0] count_q, count_d;
    logic [BUS_WIDTH-1:0]      y_q, y_d;
    logic [BUS_WIDTH_BITS:0]   shamt_q, shamt_d;
    logic                      zero_q, zero_d;
    logic                      done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            y_q     <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            y_q     <= y_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    // Results hold between finishes; done is only ever asserted at the finishing edge.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        y_d     = y_q;
        shamt_d = shamt_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.A;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (work_q == '0) begin
                    y_d     = '0;
                    shamt_d = '0;
                    zero_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (work_q[BUS_WIDTH-1]) begin
                    y_d     = work_q;
                    shamt_d = {1'b0, count_q};
                    zero_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // At most BUS_WIDTH-1 shifts for nonzero work, so count cannot wrap.
                    work_d  = work_q << 1;
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == SHIFT);
        bus.done  = done_q;
        bus.Y     = y_q;
        bus.SHAMT = shamt_q;
        bus.ZERO  = zero_q;
    end
endmodule

// File: tb/tb_normalize_shift.sv
// Directed bench for normalize_shift with a queue of expected results checked on done.
module tb_normalize_shift;
    logic clk;
    logic rst_n;

    normalize_shift_if #(.BUS_WIDTH(8), .BUS_WIDTH_BITS(3)) bus ();

    normalize_shift #(.BUS_WIDTH(8), .BUS_WIDTH_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] y;
        logic [3:0] shamt;
        logic       zero;
        int         busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a);
        exp_t e;
        int   k;
        e.a = a;
        if (a == 8'h00) begin
            e.y = 8'h00; e.shamt = 4'h0; e.zero = 1'b1; e.busy_cycles = 1;
        end else begin
            k = 0;
            while (a[7-k] == 1'b0) k++;
            e.y = a << k; e.shamt = 4'(k); e.zero = 1'b0; e.busy_cycles = k + 1;
        end
        return e;
    endfunction

    // Scoreboard consumer: one popped entry per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                dones++;
                check("done_single_cycle", done_prev, 0);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("Y", bus.Y, e.y);
                    check("SHAMT", bus.SHAMT, e.shamt);
                    check("ZERO", bus.ZERO, e.zero);
                    check("busy_cycles", busy_cnt, e.busy_cycles);
                    check("shamt_dir_bit", bus.SHAMT[3], 0);
                    if (!e.zero) begin
                        check("restore_A", bus.Y >> bus.SHAMT[2:0], e.a);
                        check("Y_msb", bus.Y[7], 1);
                    end
                    $display("txn A=%02h Y=%02h SHAMT=%04b ZERO=%0b busy=%0d",
                             e.a, bus.Y, bus.SHAMT, bus.ZERO, busy_cnt);
                end
                busy_cnt = 0;
            end
            done_prev = bus.done;
        end
    end

    task automatic run(input logic [7:0] a);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.A     = a;
        sb.push_back(model(a));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A     = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
    endtask

    initial begin
        int found;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_Y", bus.Y, 0);
        check("rst_SHAMT", bus.SHAMT, 0);
        check("rst_ZERO", bus.ZERO, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(8'h80); wait_idle();
        run(8'h01); wait_idle();
        run(8'h13); wait_idle();
        run(8'h00); wait_idle();
        check("zero_held", bus.ZERO, 1);
        run(8'h40); wait_idle();
        check("zero_cleared", bus.ZERO, 0);

        // Start while busy is ignored; start held high across done is accepted back-to-back.
        run(8'h01);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        @(posedge clk); #1;
        bus.A     = 8'h20;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("done_seen", found, 1);
        sb.push_back(model(8'h20));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        wait_idle();

        // Asynchronous reset mid-operation discards the in-flight result.
        run(8'h01);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_Y", bus.Y, 0);
        check("arst_SHAMT", bus.SHAMT, 0);
        check("arst_ZERO", bus.ZERO, 0);
        sb.delete();
        #5;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        run(8'h04); wait_idle();

        repeat (3) @(posedge clk);
        check("done_total", dones, 8);
        check("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
